// File: rtl/dx_issue_pkg.sv
// Shared decode constants, field positions and state types for the DX issue stage
// and the units that reuse its source-register decoding.
package dx_issue_pkg;

   localparam int OP_HI  = 31;
   localparam int OP_LO  = 27;
   localparam int RD_HI  = 26;
   localparam int RD_LO  = 22;
   localparam int RS_HI  = 21;
   localparam int RS_LO  = 17;
   localparam int RT_HI  = 16;
   localparam int RT_LO  = 12;
   localparam int ALU_HI = 6;
   localparam int ALU_LO = 2;

   localparam logic [4:0] RTYPE = 5'b00000;
   localparam logic [4:0] J     = 5'b00001;
   localparam logic [4:0] BNE   = 5'b00010;
   localparam logic [4:0] JAL   = 5'b00011;
   localparam logic [4:0] JR    = 5'b00100;
   localparam logic [4:0] ADDI  = 5'b00101;
   localparam logic [4:0] BLT   = 5'b00110;
   localparam logic [4:0] SW    = 5'b00111;
   localparam logic [4:0] LW    = 5'b01000;
   localparam logic [4:0] SETX  = 5'b10101;
   localparam logic [4:0] BEX   = 5'b10110;

   localparam logic [4:0] MUL   = 5'b00110;
   localparam logic [4:0] DIV   = 5'b00111;

   // bex tests the status register implicitly
   localparam logic [4:0] R_STATUS = 5'd30;

   typedef enum logic {
      RUN     = 1'b0,
      MD_WAIT = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      LD_FD     = 2'd0,
      LD_BUBBLE = 2'd1,
      LD_HOLD   = 2'd2
   } ld_sel_t;

   function automatic logic f_is_multdiv(input logic [31:0] insn);
      return (insn[OP_HI:OP_LO] == RTYPE) &&
             ((insn[ALU_HI:ALU_LO] == MUL) || (insn[ALU_HI:ALU_LO] == DIV));
   endfunction

endpackage

// File: rtl/dx_src_regs.sv
// Combinational opcode -> source-register select and use-flag decode.
// Shared by the issue stage hazard check and the bypass unit.
module dx_src_regs
   import dx_issue_pkg::*;
(
   input  logic [31:0] i_insn,
   output logic [4:0]  o_src1,
   output logic        o_use1,
   output logic [4:0]  o_src2,
   output logic        o_use2
);

   logic [4:0] w_op;
   logic [4:0] w_rd;
   logic [4:0] w_rs;
   logic [4:0] w_rt;

   assign w_op = i_insn[OP_HI:OP_LO];
   assign w_rd = i_insn[RD_HI:RD_LO];
   assign w_rs = i_insn[RS_HI:RS_LO];
   assign w_rt = i_insn[RT_HI:RT_LO];

   always_comb begin
      o_src1 = '0;
      o_use1 = 1'b0;
      o_src2 = '0;
      o_use2 = 1'b0;
      case (w_op)
         RTYPE: begin
            o_src1 = w_rs;
            o_use1 = 1'b1;
            o_src2 = w_rt;
            o_use2 = 1'b1;
         end
         ADDI, LW: begin
            o_src1 = w_rs;
            o_use1 = 1'b1;
         end
         // stores and compares read the rd field as a source
         SW, BNE, BLT: begin
            o_src1 = w_rd;
            o_use1 = 1'b1;
            o_src2 = w_rs;
            o_use2 = 1'b1;
         end
         JR: begin
            o_src1 = w_rd;
            o_use1 = 1'b1;
         end
         BEX: begin
            o_src1 = R_STATUS;
            o_use1 = 1'b1;
         end
         default: begin
            o_use1 = 1'b0;
            o_use2 = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/dx_issue.sv
// Decode-to-execute issue stage: DX latch with load-use bubbles, multdiv hold and
// redirect squash. One cycle FD->DX; stall_fd is combinational.
module dx_issue
   import dx_issue_pkg::*;
#(
   parameter int BUBBLE_CNT_W = 16
)(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    fd_valid,
   input  logic [31:0]             fd_insn,
   input  logic [31:0]             fd_pc,
   input  logic [31:0]             fd_a,
   input  logic [31:0]             fd_b,
   input  logic                    ex_redirect,
   input  logic                    md_ready,
   output logic                    dx_valid,
   output logic [31:0]             dx_insn,
   output logic [31:0]             dx_pc,
   output logic [31:0]             dx_a,
   output logic [31:0]             dx_b,
   output logic                    md_start,
   output logic                    stall_fd,
   output logic [BUBBLE_CNT_W-1:0] bubble_count
);

   state_t                  r_state;
   state_t                  w_state_nxt;
   ld_sel_t                 w_ld_sel;
   logic                    w_stall;
   logic                    w_bump;
   logic                    w_md_start_nxt;

   logic                    r_dx_valid;
   logic [31:0]             r_dx_insn;
   logic [31:0]             r_dx_pc;
   logic [31:0]             r_dx_a;
   logic [31:0]             r_dx_b;
   logic                    r_md_start;
   logic [BUBBLE_CNT_W-1:0] r_count;

   logic [4:0]              w_src1;
   logic [4:0]              w_src2;
   logic                    w_use1;
   logic                    w_use2;
   logic [4:0]              w_dx_op;
   logic [4:0]              w_dx_rd;
   logic                    w_hazard;
   logic                    w_fd_md;

   dx_src_regs u_src_regs (
      .i_insn (fd_insn),
      .o_src1 (w_src1),
      .o_use1 (w_use1),
      .o_src2 (w_src2),
      .o_use2 (w_use2)
   );

   assign w_dx_op = r_dx_insn[OP_HI:OP_LO];
   assign w_dx_rd = r_dx_insn[RD_HI:RD_LO];

   assign w_hazard = r_dx_valid && (w_dx_op == LW) && (w_dx_rd != 5'd0) && fd_valid &&
                     ((w_use1 && (w_src1 == w_dx_rd)) || (w_use2 && (w_src2 == w_dx_rd)));

   assign w_fd_md = fd_valid && f_is_multdiv(fd_insn);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // a completing multdiv falls through to the RUN decisions in the same cycle
   always_comb begin
      w_state_nxt = r_state;
      if (ex_redirect) begin
         w_state_nxt = RUN;
      end else if ((r_state == MD_WAIT) && !md_ready) begin
         w_state_nxt = MD_WAIT;
      end else if (w_hazard) begin
         w_state_nxt = RUN;
      end else if (w_fd_md) begin
         w_state_nxt = MD_WAIT;
      end else begin
         w_state_nxt = RUN;
      end
   end

   always_comb begin
      w_ld_sel       = LD_FD;
      w_stall        = 1'b0;
      w_bump         = 1'b0;
      w_md_start_nxt = 1'b0;
      if (ex_redirect) begin
         w_ld_sel = LD_BUBBLE;
      end else if ((r_state == MD_WAIT) && !md_ready) begin
         w_ld_sel = LD_HOLD;
         w_stall  = 1'b1;
         w_bump   = 1'b1;
      end else if (w_hazard) begin
         w_ld_sel = LD_BUBBLE;
         w_stall  = 1'b1;
         w_bump   = 1'b1;
      end else begin
         w_md_start_nxt = w_fd_md;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_dx_valid <= 1'b0;
         r_dx_insn  <= '0;
         r_dx_pc    <= '0;
         r_dx_a     <= '0;
         r_dx_b     <= '0;
         r_md_start <= 1'b0;
         r_count    <= '0;
      end else begin
         case (w_ld_sel)
            LD_BUBBLE: begin
               r_dx_valid <= 1'b0;
               r_dx_insn  <= '0;
               r_dx_pc    <= '0;
               r_dx_a     <= '0;
               r_dx_b     <= '0;
            end
            LD_FD: begin
               r_dx_valid <= fd_valid;
               r_dx_insn  <= fd_valid ? fd_insn : 32'd0;
               r_dx_pc    <= fd_pc;
               r_dx_a     <= fd_a;
               r_dx_b     <= fd_b;
            end
            default: begin
               r_dx_valid <= r_dx_valid;
            end
         endcase
         r_md_start <= w_md_start_nxt;
         if (w_bump && (r_count != {BUBBLE_CNT_W{1'b1}})) begin
            r_count <= r_count + BUBBLE_CNT_W'(1);
         end
      end
   end

   assign dx_valid     = r_dx_valid;
   assign dx_insn      = r_dx_insn;
   assign dx_pc        = r_dx_pc;
   assign dx_a         = r_dx_a;
   assign dx_b         = r_dx_b;
   assign md_start     = r_md_start;
   assign stall_fd     = w_stall;
   assign bubble_count = r_count;

endmodule

// File: tb/tb_dx_issue.sv
// Randomized and directed bench for dx_issue against a rule-level reference model.
module tb_dx_issue;

   localparam int CW     = 4;
   localparam int CNTMAX = (1 << CW) - 1;

   localparam logic [4:0] O_R = 5'd0, O_J = 5'd1, O_BNE = 5'd2, O_JAL = 5'd3, O_JR = 5'd4,
                          O_ADDI = 5'd5, O_BLT = 5'd6, O_SW = 5'd7, O_LW = 5'd8,
                          O_SETX = 5'd21, O_BEX = 5'd22;
   localparam logic [4:0] A_ADD = 5'd0, A_MUL = 5'd6, A_DIV = 5'd7;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          fd_valid = 1'b0;
   logic [31:0]   fd_insn = '0, fd_pc = '0, fd_a = '0, fd_b = '0;
   logic          ex_redirect = 1'b0;
   logic          md_ready = 1'b0;
   logic          dx_valid;
   logic [31:0]   dx_insn, dx_pc, dx_a, dx_b;
   logic          md_start;
   logic          stall_fd;
   logic [CW-1:0] bubble_count;

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   bit          m_v;
   logic [31:0] m_insn, m_pc, m_a, m_b;
   bit          m_wait;
   bit          m_mds;
   int          m_cnt;

   dx_issue #(.BUBBLE_CNT_W(CW)) dut (
      .clock        (clock),
      .reset        (reset),
      .fd_valid     (fd_valid),
      .fd_insn      (fd_insn),
      .fd_pc        (fd_pc),
      .fd_a         (fd_a),
      .fd_b         (fd_b),
      .ex_redirect  (ex_redirect),
      .md_ready     (md_ready),
      .dx_valid     (dx_valid),
      .dx_insn      (dx_insn),
      .dx_pc        (dx_pc),
      .dx_a         (dx_a),
      .dx_b         (dx_b),
      .md_start     (md_start),
      .stall_fd     (stall_fd),
      .bubble_count (bubble_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] alu);
      return {op, rd, rs, rt, 5'd0, alu, 2'd0};
   endfunction

   // does instruction insn read register r?
   function automatic bit reads(input logic [31:0] insn, input logic [4:0] r);
      logic [4:0] rd, rs, rt;
      rd = insn[26:22];
      rs = insn[21:17];
      rt = insn[16:12];
      case (insn[31:27])
         O_R:               return (r == rs) || (r == rt);
         O_ADDI, O_LW:      return r == rs;
         O_SW, O_BNE, O_BLT: return (r == rd) || (r == rs);
         O_JR:              return r == rd;
         O_BEX:             return r == 5'd30;
         default:           return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      m_v = 0; m_insn = '0; m_pc = '0; m_a = '0; m_b = '0;
      m_wait = 0; m_mds = 0; m_cnt = 0;
   endtask

   task automatic check_outputs(input string sfx);
      check({"dx_valid", sfx}, 64'(dx_valid), 64'(m_v));
      check({"dx_insn", sfx}, 64'(dx_insn), 64'(m_insn));
      check({"dx_pc", sfx}, 64'(dx_pc), 64'(m_pc));
      check({"dx_a", sfx}, 64'(dx_a), 64'(m_a));
      check({"dx_b", sfx}, 64'(dx_b), 64'(m_b));
      check({"md_start", sfx}, 64'(md_start), 64'(m_mds));
      check({"bubble_count", sfx}, 64'(bubble_count), 64'(m_cnt));
   endtask

   task automatic step(input bit v, input logic [31:0] insn, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b,
                       input bit redir, input bit mdr);
      bit ld_fd, ld_bub, md, st, bump, lu;
      @(negedge clock);
      fd_valid = v; fd_insn = insn; fd_pc = pc; fd_a = a; fd_b = b;
      ex_redirect = redir; md_ready = mdr;
      #1;
      ld_fd = 0; ld_bub = 0; md = 0; st = 0; bump = 0;
      lu = m_v && (m_insn[31:27] == O_LW) && (m_insn[26:22] != 5'd0) && v &&
           reads(insn, m_insn[26:22]);
      if (redir) begin
         ld_bub = 1; m_wait = 0;
      end else if (m_wait && !mdr) begin
         st = 1; bump = 1;
      end else begin
         m_wait = 0;
         if (lu) begin
            ld_bub = 1; st = 1; bump = 1;
         end else begin
            ld_fd = 1;
            md = v && (insn[31:27] == O_R) && ((insn[6:2] == A_MUL) || (insn[6:2] == A_DIV));
            m_wait = md;
         end
      end
      check("stall_fd", 64'(stall_fd), 64'(st));
      @(posedge clock);
      #1;
      if (ld_bub) begin
         m_v = 0; m_insn = '0; m_pc = '0; m_a = '0; m_b = '0;
      end else if (ld_fd) begin
         m_v = v; m_insn = v ? insn : 32'd0; m_pc = pc; m_a = a; m_b = b;
      end
      m_mds = md;
      if (bump && m_cnt < CNTMAX) m_cnt++;
      check_outputs("");
   endtask

   task automatic go(input logic [31:0] insn, input bit redir, input bit mdr);
      step(1'b1, insn, $urandom, $urandom, $urandom, redir, mdr);
   endtask

   task automatic do_reset();
      @(negedge clock);
      #2;
      reset = 1'b1;
      fd_valid = 0; ex_redirect = 0; md_ready = 0;
      #1;
      model_reset();
      check_outputs("_rst");
      check("stall_fd_rst", 64'(stall_fd), 64'd0);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      logic [4:0] ops [11];
      logic [4:0] alus [4];
      logic [4:0] op, rd;
      ops  = '{O_R, O_J, O_BNE, O_JAL, O_JR, O_ADDI, O_BLT, O_SW, O_LW, O_SETX, O_BEX};
      alus = '{A_ADD, A_MUL, A_DIV, 5'd2};
      model_reset();
      #1;
      check_outputs("_por");
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      // straight line
      go(mk(O_ADDI, 5'd1, 5'd0, 5'd0, 5'd5), 0, 0);
      go(mk(O_R, 5'd2, 5'd1, 5'd1, A_ADD), 0, 0);
      check("straight_count", 64'(bubble_count), 64'd0);
      // load-use: FD holds the add while the bubble goes out
      go(mk(O_LW, 5'd3, 5'd1, 5'd0, 5'd0), 0, 0);
      go(mk(O_R, 5'd4, 5'd3, 5'd2, A_ADD), 0, 0);
      check("lu_bubble_insn", 64'(dx_insn), 64'd0);
      go(mk(O_R, 5'd4, 5'd3, 5'd2, A_ADD), 0, 0);
      check("lu_count", 64'(bubble_count), 64'd1);
      // no false hazards
      go(mk(O_LW, 5'd0, 5'd1, 5'd0, 5'd0), 0, 0);
      go(mk(O_R, 5'd4, 5'd0, 5'd0, A_ADD), 0, 0);
      go(mk(O_LW, 5'd3, 5'd1, 5'd0, 5'd0), 0, 0);
      go(mk(O_J, 5'd3, 5'd3, 5'd3, 5'd0), 0, 0);
      check("nofalse_count", 64'(bubble_count), 64'd1);
      // multdiv, ready three cycles after md_start
      go(mk(O_R, 5'd5, 5'd1, 5'd2, A_MUL), 0, 0);
      check("mul_start", 64'(md_start), 64'd1);
      go(mk(O_ADDI, 5'd6, 5'd5, 5'd0, 5'd0), 0, 0);
      go(mk(O_ADDI, 5'd6, 5'd5, 5'd0, 5'd0), 0, 0);
      go(mk(O_ADDI, 5'd6, 5'd5, 5'd0, 5'd0), 0, 0);
      go(mk(O_ADDI, 5'd6, 5'd5, 5'd0, 5'd0), 0, 1);
      check("mul_count", 64'(bubble_count), 64'd4);
      // zero-wait multdiv completion
      go(mk(O_R, 5'd5, 5'd1, 5'd2, A_DIV), 0, 0);
      go(mk(O_ADDI, 5'd7, 5'd1, 5'd0, 5'd0), 0, 1);
      // redirect beats a pending load-use
      go(mk(O_LW, 5'd3, 5'd1, 5'd0, 5'd0), 0, 0);
      go(mk(O_R, 5'd4, 5'd3, 5'd2, A_ADD), 1, 0);
      check("redir_count", 64'(bubble_count), 64'd4);
      // redirect during MD_WAIT
      go(mk(O_R, 5'd5, 5'd1, 5'd2, A_MUL), 0, 0);
      go(mk(O_ADDI, 5'd6, 5'd5, 5'd0, 5'd0), 0, 0);
      go(mk(O_ADDI, 5'd6, 5'd5, 5'd0, 5'd0), 1, 0);
      go(mk(O_ADDI, 5'd6, 5'd5, 5'd0, 5'd0), 0, 0);
      // async reset mid MD_WAIT, then resume in RUN
      go(mk(O_R, 5'd5, 5'd1, 5'd2, A_MUL), 0, 0);
      go(mk(O_ADDI, 5'd6, 5'd5, 5'd0, 5'd0), 0, 0);
      do_reset();
      go(mk(O_ADDI, 5'd6, 5'd5, 5'd0, 5'd0), 0, 0);

      for (int i = 0; i < 3000; i++) begin
         logic [31:0] insn;
         op = ops[$urandom_range(0, 10)];
         if ($urandom_range(0, 3) == 0) op = O_LW;
         rd = 5'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) rd = 5'd30;
         insn = {op, rd, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom), alus[$urandom_range(0, 3)], 2'($urandom)};
         step($urandom_range(0, 7) != 0, insn, $urandom, $urandom, $urandom,
              $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
         if (i % 700 == 699) do_reset();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/dx_issue.md
Name: dx_issue

Overview:
Decode-to-execute issue stage. It is the producing end of the opcode/operand interface that the execute-stage control decoder consumes. It registers the decoded instruction, PC and operands into the DX latch, inserts load-use bubbles, holds on multdiv operations, and squashes on execute redirects. It sits between register-file read and the execute stage of the 5-stage pipeline.

Parameters:
BUBBLE_CNT_W, 16, width of the saturating bubble/stall performance counter.

Ports:
clock  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
fd_valid  in  1  FD latch holds a real instruction.
fd_insn  in  32  FD instruction. Fields: opcode[31:27], rd[26:22], rs[21:17], rt[16:12], aluop[6:2].
fd_pc  in  32  PC of the FD instruction.
fd_a  in  32  register-file read data A.
fd_b  in  32  register-file read data B.
ex_redirect  in  1  execute resolved a taken branch or jump this cycle.
md_ready  in  1  multdiv result ready; single-cycle pulse.
dx_valid  out  1  DX holds a real instruction.
dx_insn  out  32  instruction to execute; a bubble is all zeros.
dx_pc  out  32  PC carried with dx_insn.
dx_a  out  32  operand A carried with dx_insn.
dx_b  out  32  operand B carried with dx_insn.
md_start  out  1  one-cycle pulse: a mul/div became valid in DX.
stall_fd  out  1  PC and FD latch must hold this cycle.
bubble_count  out  BUBBLE_CNT_W  saturating count of bubble and hold cycles.

Behaviour:
- Reset, async: all outputs 0, state RUN. Reset mid-multdiv abandons the operation; md_start stays 0.
- States:
  - RUN: DX loads from FD every cycle unless stalled.
  - MD_WAIT: DX is held.
- Next-DX decision, evaluated each cycle in priority order:
  1. ex_redirect=1: DX loads a bubble (valid=0, insn=0). The FD content is discarded. State goes to RUN. stall_fd=0.
  2. state MD_WAIT and md_ready=0: DX is held and stall_fd=1.
  3. state MD_WAIT and md_ready=1: state goes to RUN. The same cycle proceeds as RUN, so there is no dead cycle.
  4. Load-use: all of the following hold:
     - dx_valid=1, and dx opcode is lw (01000);
     - dx rd is nonzero;
     - fd_valid=1;
     - dx rd equals one of FD's source registers.
     Result: DX loads a bubble and stall_fd=1. This is exactly one bubble per hazard.
  5. Otherwise: DX loads {fd_valid, fd_insn, fd_pc, fd_a, fd_b}. If fd_valid=0, dx_insn is forced to 0.
- FD source registers by opcode:
  - R-type 00000: rs, rt.
  - addi 00101, lw 01000: rs.
  - sw 00111, bne 00010, blt 00110: rd, rs.
  - jr 00100: rd.
  - bex 10110: r30.
  - j 00001, jal 00011, setx 10101: none.
- Multdiv:
  - When case 5 loads a valid R-type instruction with aluop 00110 (mul) or 00111 (div), md_start=1 in the following cycle, aligned with dx_valid.
  - In that same cycle the state enters MD_WAIT and stall_fd=1.
  - An md_ready in the same cycle as md_start is honoured (zero-wait completion).
- stall_fd is combinational from current state and inputs. It is never asserted during a redirect.
- bubble_count increments by 1 on each cycle in which case 2 or case 4 applies. It saturates at all-ones.
- A dx rd equal to 0 never creates a hazard.

Decomposition:
- Shared package:
  - opcode constants: RTYPE, ADDI, SW, LW, J, BNE, JAL, JR, BLT, BEX, SETX;
  - aluop constants MUL, DIV;
  - instruction field bit positions;
  - the state enum {RUN, MD_WAIT}.
- One sub-module, dx_src_regs: a combinational mapping from opcode to source-register selects and their use flags. It is shared with the bypass unit.

Test Plan:
- Straight-line: addi r1,r0,5 then add r2,r1,r1 with fd_valid=1 -> each appears in DX one cycle later; stall_fd=0; bubble_count=0.
- Load-use: lw r3,0(r1) followed by add r4,r3,r2 -> one cycle with dx_valid=0, dx_insn=0 and stall_fd=1; add enters DX the next cycle; bubble_count=1.
- No false hazard:
  - lw r0 followed by add r4,r0,r0 -> no bubble.
  - lw r3 followed by j -> no bubble.
- Multdiv: mul r5,r1,r2 with md_ready arriving 3 cycles after md_start -> md_start high for 1 cycle; DX held for 3 cycles with stall_fd=1; the next instruction enters DX on the cycle after md_ready; bubble_count=3.
- Redirect priority: ex_redirect=1 while a load-use hazard is pending -> DX gets a bubble, stall_fd=0, bubble_count unchanged.
- Redirect during MD_WAIT -> state RUN next cycle, DX a bubble.
- Async reset asserted mid-MD_WAIT -> all outputs 0 immediately with no clock edge; the cycle after release resumes in RUN.
